// File: rtl/pipeline_mem_stage_hs.sv
// EX->WB memory stage: valid/ready intake from EX, req/ack data bus, store lane alignment, load extension.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned loads/stores instead of issuing them.
module pipeline_mem_stage_hs #(
   parameter int XLEN = 64,
   parameter int RA_W = 5
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [XLEN-1:0]   ex_alu_result,
   input  logic [XLEN-1:0]   ex_store_data,
   input  logic [RA_W-1:0]   ex_rd,
   input  logic [XLEN-1:0]   ex_pc,
   input  logic [2:0]        ex_rd_ctrl,
   input  logic [2:0]        ex_wr_ctrl,
   input  logic              ex_rf_wr_en,
   input  logic [1:0]        ex_rf_wr_sel,
   output logic              bus_req,
   output logic              bus_we,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_wstrb,
   input  logic              bus_ack,
   input  logic [XLEN-1:0]   bus_rdata,
   output logic              busy,
   output logic              wb_valid,
   output logic [XLEN-1:0]   wb_pc,
   output logic [XLEN-1:0]   wb_alu_result,
   output logic [XLEN-1:0]   wb_mem_data,
   output logic [RA_W-1:0]   wb_rd,
   output logic              wb_rf_wr_en,
   output logic [1:0]        wb_rf_wr_sel,
   output logic              misalign
);
   localparam int NB    = XLEN / 8;
   localparam int OFF_W = $clog2(NB);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state_q, state_d;
   logic             bus_req_q, bus_req_d, bus_we_q, bus_we_d;
   logic [XLEN-1:0]  bus_addr_q, bus_addr_d, bus_wdata_q, bus_wdata_d;
   logic [NB-1:0]    bus_wstrb_q, bus_wstrb_d;
   logic [OFF_W-1:0] off_q, off_d;
   logic [1:0]       ld_size_q, ld_size_d;
   logic             ld_sgn_q, ld_sgn_d;
   logic             wb_valid_q, wb_valid_d, misalign_q, misalign_d;
   logic [XLEN-1:0]  wb_pc_q, wb_pc_d, wb_alu_q, wb_alu_d, wb_mem_q, wb_mem_d;
   logic [RA_W-1:0]  wb_rd_q, wb_rd_d;
   logic             wb_wr_en_q, wb_wr_en_d;
   logic [1:0]       wb_sel_q, wb_sel_d;

   logic             ld_en, st_en, ld_sgn, mem_op, trap;
   logic [1:0]       ld_size, st_size, acc_size;
   logic [OFF_W-1:0] ex_off;
   logic [NB-1:0]    strb_base;

   // Codes that need a 64-bit datapath decode as "none" on XLEN=32.
   always_comb begin
      ld_en   = 1'b0;
      ld_size = 2'd0;
      ld_sgn  = 1'b0;
      case (ex_rd_ctrl)
         3'd1: begin ld_en = 1'b1; ld_size = 2'd0; ld_sgn = 1'b1; end
         3'd2: begin ld_en = 1'b1; ld_size = 2'd0; end
         3'd3: begin ld_en = 1'b1; ld_size = 2'd1; ld_sgn = 1'b1; end
         3'd4: begin ld_en = 1'b1; ld_size = 2'd1; end
         3'd5: begin ld_en = 1'b1; ld_size = 2'd2; ld_sgn = 1'b1; end
         3'd6: begin ld_en = (XLEN == 64); ld_size = 2'd2; end
         3'd7: begin ld_en = (XLEN == 64); ld_size = 2'd3; end
         default: ;
      endcase
      st_en   = 1'b1;
      st_size = 2'd0;
      case (ex_wr_ctrl)
         3'd1: st_size = 2'd0;
         3'd2: st_size = 2'd1;
         3'd3: st_size = 2'd2;
         3'd4: begin st_en = (XLEN == 64); st_size = 2'd3; end
         default: st_en = 1'b0;
      endcase
      case (st_size)
         2'd0:    strb_base = NB'(1);
         2'd1:    strb_base = NB'(3);
         2'd2:    strb_base = NB'(15);
         default: strb_base = NB'(255);
      endcase
   end

   assign mem_op   = st_en | ld_en;
   assign acc_size = st_en ? st_size : ld_size;
   assign ex_off   = ex_alu_result[OFF_W-1:0];

`ifdef MEM_MISALIGN_TRAP_EN
   logic [OFF_W-1:0] size_mask;
   always_comb begin
      case (acc_size)
         2'd0:    size_mask = '0;
         2'd1:    size_mask = OFF_W'(1);
         2'd2:    size_mask = OFF_W'(3);
         default: size_mask = OFF_W'(7);
      endcase
   end
   assign trap = mem_op && (|(ex_off & size_mask));
`else
   assign trap = 1'b0;
`endif

   // Load return: move the addressed lane to bit 0, then extend.
   logic [XLEN-1:0] rd_shift, keep_mask, ld_data;
   logic            sbit;
   always_comb begin
      rd_shift = bus_rdata >> {off_q, 3'b000};
      case (ld_size_q)
         2'd0:    begin keep_mask = XLEN'(64'hFF);        sbit = rd_shift[7];  end
         2'd1:    begin keep_mask = XLEN'(64'hFFFF);      sbit = rd_shift[15]; end
         2'd2:    begin keep_mask = XLEN'(64'hFFFF_FFFF); sbit = rd_shift[31]; end
         default: begin keep_mask = '1;                   sbit = 1'b0;         end
      endcase
      ld_data = (rd_shift & keep_mask) | ({XLEN{ld_sgn_q & sbit}} & ~keep_mask);
   end

   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_wdata_d = bus_wdata_q;
      bus_wstrb_d = bus_wstrb_q;
      off_d       = off_q;
      ld_size_d   = ld_size_q;
      ld_sgn_d    = ld_sgn_q;
      wb_pc_d     = wb_pc_q;
      wb_alu_d    = wb_alu_q;
      wb_mem_d    = wb_mem_q;
      wb_rd_d     = wb_rd_q;
      wb_wr_en_d  = wb_wr_en_q;
      wb_sel_d    = wb_sel_q;
      wb_valid_d  = 1'b0;
      misalign_d  = 1'b0;
      case (state_q)
         IDLE: if (ex_valid) begin
            wb_pc_d    = ex_pc;
            wb_alu_d   = ex_alu_result;
            wb_rd_d    = ex_rd;
            wb_wr_en_d = ex_rf_wr_en;
            wb_sel_d   = ex_rf_wr_sel;
            if (mem_op && !trap) begin
               state_d     = ACCESS;
               bus_req_d   = 1'b1;
               bus_we_d    = st_en;
               bus_addr_d  = {ex_alu_result[XLEN-1:OFF_W], {OFF_W{1'b0}}};
               bus_wdata_d = st_en ? (ex_store_data << {ex_off, 3'b000}) : '0;
               bus_wstrb_d = st_en ? (strb_base << ex_off) : '1;
               off_d       = ex_off;
               ld_size_d   = ld_size;
               ld_sgn_d    = ld_sgn;
            end else begin
               wb_valid_d = 1'b1;
               wb_mem_d   = '0;
               if (trap) begin
                  misalign_d = 1'b1;
                  wb_wr_en_d = 1'b0;
               end
            end
         end
         ACCESS: if (bus_ack) begin
            state_d    = IDLE;
            bus_req_d  = 1'b0;
            wb_valid_d = 1'b1;
            wb_mem_d   = bus_we_q ? '0 : ld_data;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_wdata_q <= '0;
         bus_wstrb_q <= '0;
         off_q       <= '0;
         ld_size_q   <= '0;
         ld_sgn_q    <= 1'b0;
         wb_valid_q  <= 1'b0;
         misalign_q  <= 1'b0;
         wb_pc_q     <= '0;
         wb_alu_q    <= '0;
         wb_mem_q    <= '0;
         wb_rd_q     <= '0;
         wb_wr_en_q  <= 1'b0;
         wb_sel_q    <= '0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_wdata_q <= bus_wdata_d;
         bus_wstrb_q <= bus_wstrb_d;
         off_q       <= off_d;
         ld_size_q   <= ld_size_d;
         ld_sgn_q    <= ld_sgn_d;
         wb_valid_q  <= wb_valid_d;
         misalign_q  <= misalign_d;
         wb_pc_q     <= wb_pc_d;
         wb_alu_q    <= wb_alu_d;
         wb_mem_q    <= wb_mem_d;
         wb_rd_q     <= wb_rd_d;
         wb_wr_en_q  <= wb_wr_en_d;
         wb_sel_q    <= wb_sel_d;
      end
   end

   // ex_ready is held low while reset is asserted so every output reads 0.
   assign ex_ready      = reset && (state_q == IDLE);
   assign bus_req       = bus_req_q;
   assign busy          = bus_req_q;
   assign bus_we        = bus_we_q;
   assign bus_addr      = bus_addr_q;
   assign bus_wdata     = bus_wdata_q;
   assign bus_wstrb     = bus_wstrb_q;
   assign wb_valid      = wb_valid_q;
   assign wb_pc         = wb_pc_q;
   assign wb_alu_result = wb_alu_q;
   assign wb_mem_data   = wb_mem_q;
   assign wb_rd         = wb_rd_q;
   assign wb_rf_wr_en   = wb_valid_q & wb_wr_en_q;
   assign wb_rf_wr_sel  = wb_sel_q;
   assign misalign      = misalign_q;

endmodule

// File: tb/tb_pipeline_mem_stage_hs.sv
// Directed self-checking bench for pipeline_mem_stage_hs (XLEN=64): vector table plus corner sequences.
module tb_pipeline_mem_stage_hs;
   localparam int XLEN = 64;
   localparam int RA_W = 5;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             ex_valid = 1'b0, ex_ready;
   logic [XLEN-1:0]  ex_alu_result = '0, ex_store_data = '0, ex_pc = '0;
   logic [RA_W-1:0]  ex_rd = '0;
   logic [2:0]       ex_rd_ctrl = '0, ex_wr_ctrl = '0;
   logic             ex_rf_wr_en = 1'b0;
   logic [1:0]       ex_rf_wr_sel = '0;
   logic             bus_req, bus_we, bus_ack = 1'b0, busy;
   logic [XLEN-1:0]  bus_addr, bus_wdata, bus_rdata = '0;
   logic [XLEN/8-1:0] bus_wstrb;
   logic             wb_valid, wb_rf_wr_en, misalign;
   logic [XLEN-1:0]  wb_pc, wb_alu_result, wb_mem_data;
   logic [RA_W-1:0]  wb_rd;
   logic [1:0]       wb_rf_wr_sel;

   pipeline_mem_stage_hs #(.XLEN(XLEN), .RA_W(RA_W)) dut (
      .clk(clk), .reset(reset),
      .ex_valid(ex_valid), .ex_ready(ex_ready),
      .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
      .ex_rd(ex_rd), .ex_pc(ex_pc), .ex_rd_ctrl(ex_rd_ctrl), .ex_wr_ctrl(ex_wr_ctrl),
      .ex_rf_wr_en(ex_rf_wr_en), .ex_rf_wr_sel(ex_rf_wr_sel),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_wstrb(bus_wstrb), .bus_ack(bus_ack), .bus_rdata(bus_rdata), .busy(busy),
      .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_alu_result(wb_alu_result),
      .wb_mem_data(wb_mem_data), .wb_rd(wb_rd), .wb_rf_wr_en(wb_rf_wr_en),
      .wb_rf_wr_sel(wb_rf_wr_sel), .misalign(misalign)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [2:0]  rd_ctrl;
      logic [2:0]  wr_ctrl;
      logic [63:0] addr;
      logic [63:0] sdata;
      logic [63:0] rdata;
      int          waits;
      logic        mem;
      logic [63:0] exp_addr;
      logic        exp_we;
      logic [63:0] exp_wdata;
      logic [7:0]  exp_strb;
      logic [63:0] exp_mem;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic [2:0] rc, input logic [2:0] wc, input logic [63:0] a,
                               input logic [63:0] sd, input logic [63:0] rdat, input int w,
                               input logic m, input logic [63:0] ea, input logic ewe,
                               input logic [63:0] ewd, input logic [7:0] es, input logic [63:0] em);
      vec_t v;
      v.rd_ctrl = rc; v.wr_ctrl = wc; v.addr = a; v.sdata = sd; v.rdata = rdat; v.waits = w;
      v.mem = m; v.exp_addr = ea; v.exp_we = ewe; v.exp_wdata = ewd; v.exp_strb = es; v.exp_mem = em;
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      string nm;
      logic [63:0] pc;
      nm = $sformatf("v%0d", idx);
      pc = 64'h100 + 64'(idx * 4);
      chk({nm, ".ex_ready"}, ex_ready, 1);
      ex_valid = 1'b1; ex_alu_result = v.addr; ex_store_data = v.sdata; ex_pc = pc;
      ex_rd = RA_W'(idx + 1); ex_rd_ctrl = v.rd_ctrl; ex_wr_ctrl = v.wr_ctrl;
      ex_rf_wr_en = 1'(idx % 2); ex_rf_wr_sel = 2'(idx);
      step();
      ex_valid = 1'b0;
      if (v.mem) begin
         chk({nm, ".bus_req"}, bus_req, 1);
         chk({nm, ".busy"}, busy, 1);
         chk({nm, ".ex_ready_acc"}, ex_ready, 0);
         chk({nm, ".bus_addr"}, bus_addr, v.exp_addr);
         chk({nm, ".bus_we"}, bus_we, v.exp_we);
         chk({nm, ".bus_wdata"}, bus_wdata, v.exp_wdata);
         chk({nm, ".bus_wstrb"}, bus_wstrb, v.exp_strb);
         for (int w = 0; w < v.waits; w++) begin
            step();
            chk({nm, ".req_held"}, bus_req, 1);
            chk({nm, ".addr_held"}, bus_addr, v.exp_addr);
            chk({nm, ".no_early_wb"}, wb_valid, 0);
         end
         bus_ack = 1'b1; bus_rdata = v.rdata;
         step();
         bus_ack = 1'b0; bus_rdata = '0;
         chk({nm, ".req_drop"}, bus_req, 0);
      end else begin
         chk({nm, ".no_req"}, bus_req, 0);
      end
      chk({nm, ".wb_valid"}, wb_valid, 1);
      chk({nm, ".wb_mem_data"}, wb_mem_data, v.exp_mem);
      chk({nm, ".wb_alu_result"}, wb_alu_result, v.addr);
      chk({nm, ".wb_pc"}, wb_pc, pc);
      chk({nm, ".wb_rd"}, wb_rd, 64'(idx + 1));
      chk({nm, ".wb_rf_wr_en"}, wb_rf_wr_en, 64'(idx % 2));
      chk({nm, ".wb_rf_wr_sel"}, wb_rf_wr_sel, 64'(idx % 4));
      chk({nm, ".ready_back"}, ex_ready, 1);
      step();
      chk({nm, ".wb_pulse"}, wb_valid, 0);
      chk({nm, ".wr_en_gated"}, wb_rf_wr_en, 0);
   endtask

   initial begin
      // rd_ctrl, wr_ctrl, addr, sdata, rdata, waits, mem, exp_addr, exp_we, exp_wdata, exp_strb, exp_mem
      tbl.push_back(mk(3'd0, 3'd0, 64'h1234, 64'h0, 64'h0, 0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0));
      tbl.push_back(mk(3'd0, 3'd1, 64'h1003, 64'hAB, 64'h0, 0, 1'b1, 64'h1000, 1'b1, 64'hAB00_0000, 8'h08, 64'h0));
      tbl.push_back(mk(3'd1, 3'd0, 64'h1006, 64'h0, 64'h0080_0000_0000_0000, 3, 1'b1, 64'h1000, 1'b0, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_FF80));
      tbl.push_back(mk(3'd2, 3'd0, 64'h1006, 64'h0, 64'h0080_0000_0000_0000, 0, 1'b1, 64'h1000, 1'b0, 64'h0, 8'hFF, 64'h80));
      tbl.push_back(mk(3'd3, 3'd0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 1, 1'b1, 64'h2000, 1'b0, 64'h0, 8'hFF, 64'hFFFF_FFFF_FFFF_8001));
      tbl.push_back(mk(3'd4, 3'd0, 64'h2002, 64'h0, 64'h0000_0000_8001_0000, 0, 1'b1, 64'h2000, 1'b0, 64'h0, 8'hFF, 64'h8001));
      tbl.push_back(mk(3'd5, 3'd0, 64'h2004, 64'h0, 64'h9ABC_DEF0_1234_5678, 0, 1'b1, 64'h2000, 1'b0, 64'h0, 8'hFF, 64'hFFFF_FFFF_9ABC_DEF0));
      tbl.push_back(mk(3'd6, 3'd0, 64'h2004, 64'h0, 64'h9ABC_DEF0_1234_5678, 0, 1'b1, 64'h2000, 1'b0, 64'h0, 8'hFF, 64'h9ABC_DEF0));
      tbl.push_back(mk(3'd5, 3'd0, 64'h2000, 64'h0, 64'h9ABC_DEF0_1234_5678, 0, 1'b1, 64'h2000, 1'b0, 64'h0, 8'hFF, 64'h1234_5678));
      tbl.push_back(mk(3'd7, 3'd0, 64'h3008, 64'h0, 64'h8000_0000_0000_0001, 2, 1'b1, 64'h3008, 1'b0, 64'h0, 8'hFF, 64'h8000_0000_0000_0001));
      tbl.push_back(mk(3'd0, 3'd2, 64'h1006, 64'hBEEF, 64'h0, 0, 1'b1, 64'h1000, 1'b1, 64'hBEEF_0000_0000_0000, 8'hC0, 64'h0));
      tbl.push_back(mk(3'd0, 3'd3, 64'h1004, 64'hCAFE_BABE, 64'h0, 1, 1'b1, 64'h1000, 1'b1, 64'hCAFE_BABE_0000_0000, 8'hF0, 64'h0));
      tbl.push_back(mk(3'd0, 3'd4, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 1'b1, 64'h1008, 1'b1, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0));
      tbl.push_back(mk(3'd1, 3'd1, 64'h0010, 64'h5A, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b1, 64'h0010, 1'b1, 64'h5A, 8'h01, 64'h0));
      tbl.push_back(mk(3'd0, 3'd5, 64'hDEAD, 64'h77, 64'h0, 0, 1'b0, 64'h0, 1'b0, 64'h0, 8'h00, 64'h0));
`ifndef MEM_MISALIGN_TRAP_EN
      tbl.push_back(mk(3'd0, 3'd2, 64'h1007, 64'hBEEF, 64'h0, 0, 1'b1, 64'h1000, 1'b1, 64'hEF00_0000_0000_0000, 8'h80, 64'h0));
      tbl.push_back(mk(3'd5, 3'd0, 64'h1002, 64'h0, 64'h0000_8765_4321_0000, 0, 1'b1, 64'h1000, 1'b0, 64'h0, 8'hFF, 64'hFFFF_FFFF_8765_4321));
`endif

      // Reset state
      step();
      chk("rst.ex_ready", ex_ready, 0);
      chk("rst.bus_req", bus_req, 0);
      chk("rst.busy", busy, 0);
      chk("rst.bus_addr", bus_addr, 0);
      chk("rst.bus_wstrb", bus_wstrb, 0);
      chk("rst.wb_valid", wb_valid, 0);
      chk("rst.wb_rf_wr_en", wb_rf_wr_en, 0);
      chk("rst.misalign", misalign, 0);
      reset = 1'b1;
      step();
      chk("rst.ready_after", ex_ready, 1);

      // Ack with no request outstanding is ignored
      bus_ack = 1'b1; bus_rdata = 64'h55;
      step();
      step();
      chk("idle_ack.wb_valid", wb_valid, 0);
      chk("idle_ack.bus_req", bus_req, 0);
      bus_ack = 1'b0; bus_rdata = '0;

      for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);

      // Back-to-back LDs, immediate ack; EX keeps the second one offered
      ex_valid = 1'b1; ex_rd_ctrl = 3'd7; ex_wr_ctrl = 3'd0; ex_alu_result = 64'h4000;
      step();
      chk("b2b.req1", bus_req, 1);
      chk("b2b.ready_low", ex_ready, 0);
      chk("b2b.addr1", bus_addr, 64'h4000);
      ex_alu_result = 64'h4008;
      bus_ack = 1'b1; bus_rdata = 64'h11;
      step();
      bus_ack = 1'b0;
      chk("b2b.wb1", wb_valid, 1);
      chk("b2b.data1", wb_mem_data, 64'h11);
      chk("b2b.ready_back", ex_ready, 1);
      chk("b2b.req_gap", bus_req, 0);
      step();
      ex_valid = 1'b0;
      chk("b2b.req2", bus_req, 1);
      chk("b2b.addr2", bus_addr, 64'h4008);
      chk("b2b.ready_low2", ex_ready, 0);
      bus_ack = 1'b1; bus_rdata = 64'h22;
      step();
      bus_ack = 1'b0;
      chk("b2b.wb2", wb_valid, 1);
      chk("b2b.data2", wb_mem_data, 64'h22);
      step();

      // Reset while a load waits for its ack
      ex_valid = 1'b1; ex_rd_ctrl = 3'd5; ex_wr_ctrl = 3'd0; ex_alu_result = 64'h5000;
      step();
      ex_valid = 1'b0;
      chk("mrst.req", bus_req, 1);
      step();
      reset = 1'b0;
      #1;
      chk("mrst.req_async", bus_req, 0);
      chk("mrst.busy", busy, 0);
      chk("mrst.addr", bus_addr, 0);
      chk("mrst.ready", ex_ready, 0);
      chk("mrst.wb_valid", wb_valid, 0);
      step();
      reset = 1'b1;
      bus_ack = 1'b1; bus_rdata = 64'h99;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("mrst.no_wb", wb_valid, 0);
         chk("mrst.no_req", bus_req, 0);
      end
      bus_ack = 1'b0;
      chk("mrst.ready_after", ex_ready, 1);

`ifdef MEM_MISALIGN_TRAP_EN
      ex_valid = 1'b1; ex_rd_ctrl = 3'd5; ex_wr_ctrl = 3'd0; ex_alu_result = 64'h1002; ex_rf_wr_en = 1'b1;
      step();
      ex_valid = 1'b0;
      chk("trap.no_req", bus_req, 0);
      chk("trap.wb_valid", wb_valid, 1);
      chk("trap.misalign", misalign, 1);
      chk("trap.wr_en", wb_rf_wr_en, 0);
      step();
      chk("trap.pulse", misalign, 0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule
